// File: rtl/bip2_pkg.sv
// Shared definitions for the BIP-2 control sequencer: opcodes, FSM states,
// accumulator source selects and the per-opcode control decode.
package bip2_pkg;
    localparam int BIP2_DATA_W = 16;
    localparam int BIP2_ADDR_W = 11;
    localparam int BIP2_OPC_W  = 5;

    localparam logic [BIP2_OPC_W-1:0] OPC_HLT  = 5'd0;
    localparam logic [BIP2_OPC_W-1:0] OPC_STO  = 5'd1;
    localparam logic [BIP2_OPC_W-1:0] OPC_LD   = 5'd2;
    localparam logic [BIP2_OPC_W-1:0] OPC_LDI  = 5'd3;
    localparam logic [BIP2_OPC_W-1:0] OPC_ADD  = 5'd4;
    localparam logic [BIP2_OPC_W-1:0] OPC_ADDI = 5'd5;
    localparam logic [BIP2_OPC_W-1:0] OPC_SUB  = 5'd6;
    localparam logic [BIP2_OPC_W-1:0] OPC_SUBI = 5'd7;
    localparam logic [BIP2_OPC_W-1:0] OPC_BEQ  = 5'd8;
    localparam logic [BIP2_OPC_W-1:0] OPC_BNE  = 5'd9;
    localparam logic [BIP2_OPC_W-1:0] OPC_BGT  = 5'd10;
    localparam logic [BIP2_OPC_W-1:0] OPC_BGE  = 5'd11;
    localparam logic [BIP2_OPC_W-1:0] OPC_BLT  = 5'd12;
    localparam logic [BIP2_OPC_W-1:0] OPC_BLE  = 5'd13;
    localparam logic [BIP2_OPC_W-1:0] OPC_JMP  = 5'd14;

    typedef enum logic [1:0] {S_FETCH, S_LOAD, S_EXEC, S_HALT} state_t;

    localparam logic [1:0] ACC_ALU = 2'b00;
    localparam logic [1:0] ACC_RAM = 2'b01;
    localparam logic [1:0] ACC_IMM = 2'b10;

    typedef struct packed {
        logic       alu_op;
        logic       alu_b_sel;
        logic [1:0] acc_sel;
        logic       wr_acc;
        logic       wr_ram;
    } ctrl_t;

    function automatic logic is_arith(input logic [BIP2_OPC_W-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_ADDI) || (opc == OPC_SUB) || (opc == OPC_SUBI);
    endfunction

    function automatic ctrl_t decode(input logic [BIP2_OPC_W-1:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_STO:  c.wr_ram = 1'b1;
            OPC_LD:   begin c.acc_sel = ACC_RAM; c.wr_acc = 1'b1; end
            OPC_LDI:  begin c.acc_sel = ACC_IMM; c.wr_acc = 1'b1; end
            OPC_ADD:  begin c.acc_sel = ACC_ALU; c.wr_acc = 1'b1; end
            OPC_ADDI: begin c.alu_b_sel = 1'b1; c.wr_acc = 1'b1; end
            OPC_SUB:  begin c.alu_op = 1'b1; c.wr_acc = 1'b1; end
            OPC_SUBI: begin c.alu_op = 1'b1; c.alu_b_sel = 1'b1; c.wr_acc = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/bip2_branch_eval.sv
// Branch condition evaluation from opcode and the Z/N status flags.
module bip2_branch_eval
    import bip2_pkg::*;
(
    input  logic [BIP2_OPC_W-1:0] i_opc,
    input  logic                  i_z,
    input  logic                  i_n,
    output logic                  o_taken
);
    always_comb begin
        o_taken = 1'b0;
        case (i_opc)
            OPC_BEQ: o_taken = i_z;
            OPC_BNE: o_taken = !i_z;
            OPC_BGT: o_taken = !i_z && !i_n;
            OPC_BGE: o_taken = !i_n;
            OPC_BLT: o_taken = i_n;
            OPC_BLE: o_taken = i_n || i_z;
            OPC_JMP: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/bip2_control_sequencer.sv
// BIP-2 multi-cycle sequencer: owns PC, IR and Z/N, runs FETCH/LOAD/EXEC and
// drives datapath strobes during EXEC only.
module bip2_control_sequencer
    import bip2_pkg::*;
#(
    parameter int DATA_W = BIP2_DATA_W,
    parameter int ADDR_W = BIP2_ADDR_W,
    parameter int OPC_W  = BIP2_OPC_W
) (
    input  logic              CLOCK_i,
    input  logic              RESET_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] imm_o,
    output logic              alu_op_o,
    output logic              alu_b_sel_o,
    output logic [1:0]        acc_sel_o,
    output logic              wr_acc_o,
    output logic              wr_ram_o,
    output logic              halted_o
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic              r_z;
    logic              r_n;
    logic              r_halted;
    ctrl_t             r_ctrl;

    logic [OPC_W-1:0]  w_opc;
    logic [OPC_W-1:0]  w_ld_opc;
    logic [ADDR_W-1:0] w_operand;
    logic              w_taken;

    assign w_opc     = r_ir[DATA_W-1 -: OPC_W];
    assign w_ld_opc  = imem_data_i[DATA_W-1 -: OPC_W];
    assign w_operand = r_ir[ADDR_W-1:0];

    bip2_branch_eval u_branch (
        .i_opc   (w_opc),
        .i_z     (r_z),
        .i_n     (r_n),
        .o_taken (w_taken)
    );

    // Controls are decoded as the instruction is latched, so they are
    // register-driven for exactly the EXEC cycle and cleared on leaving it.
    always_ff @(posedge CLOCK_i) begin
        if (!RESET_i) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_halted <= 1'b0;
            r_ctrl   <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    r_ir    <= imem_data_i;
                    r_ctrl  <= decode(w_ld_opc);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_ctrl <= '0;
                    if (w_opc == OPC_HLT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                        r_pc    <= w_taken ? w_operand : r_pc + ADDR_W'(1);
                    end
                    if (is_arith(w_opc)) begin
                        r_z <= (alu_res_i == '0);
                        r_n <= alu_res_i[DATA_W-1];
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_addr_o = r_pc;
    assign ram_addr_o  = w_operand;
    assign imm_o       = {{(DATA_W-ADDR_W){w_operand[ADDR_W-1]}}, w_operand};
    assign alu_op_o    = r_ctrl.alu_op;
    assign alu_b_sel_o = r_ctrl.alu_b_sel;
    assign acc_sel_o   = r_ctrl.acc_sel;
    assign wr_acc_o    = r_ctrl.wr_acc;
    assign wr_ram_o    = r_ctrl.wr_ram;
    assign halted_o    = r_halted;
endmodule

// File: tb/tb_bip2_control_sequencer.sv
// Directed bench for bip2_control_sequencer with a registered-read ROM model.
module tb_bip2_control_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] alu_res = 16'h0000;
    logic [10:0] ram_addr;
    logic [15:0] imm;
    logic        alu_op, alu_b_sel, wr_acc, wr_ram, halted;
    logic [1:0]  acc_sel;

    logic [15:0] rom [0:2047];
    int          n_pass = 0;
    int          n_chk  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= rom[imem_addr];

    bip2_control_sequencer dut (
        .CLOCK_i     (clk),
        .RESET_i     (rst_n),
        .imem_addr_o (imem_addr),
        .imem_data_i (imem_data),
        .alu_res_i   (alu_res),
        .ram_addr_o  (ram_addr),
        .imm_o       (imm),
        .alu_op_o    (alu_op),
        .alu_b_sel_o (alu_b_sel),
        .acc_sel_o   (acc_sel),
        .wr_acc_o    (wr_acc),
        .wr_ram_o    (wr_ram),
        .halted_o    (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 16'h7800;
    endtask

    // Leaves the DUT in FETCH at PC 0, reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = 16'h1805;
        rst_n = 1'b0;
        repeat (3) tick();
        n_chk++; if (imem_addr !== 11'h000) $display("FAIL rst_pc got %h exp %h", imem_addr, 11'h000); else n_pass++;
        n_chk++; if ({halted, wr_acc, wr_ram, acc_sel} !== 5'b0) $display("FAIL rst_ctl got %b exp %b", {halted, wr_acc, wr_ram, acc_sel}, 5'b0); else n_pass++;
        rst_n = 1'b1;
        tick(); tick();
        n_chk++; if ({wr_acc, acc_sel, imm} !== {1'b1, 2'b10, 16'h0005}) $display("FAIL rst_ldi got %h exp %h", {wr_acc, acc_sel, imm}, {1'b1, 2'b10, 16'h0005}); else n_pass++;
    endtask

    task automatic test_beq();
        clear_rom();
        rom[0] = 16'h1803; rom[1] = 16'h3803; rom[2] = 16'h4010; rom[16] = 16'h5100;
        do_reset();
        repeat (3) tick();
        tick(); tick();
        n_chk++; if ({alu_op, alu_b_sel, acc_sel, wr_acc, wr_ram} !== 6'b110010) $display("FAIL subi_ctl got %b exp %b", {alu_op, alu_b_sel, acc_sel, wr_acc, wr_ram}, 6'b110010); else n_pass++;
        alu_res = 16'h0000;
        tick();
        repeat (2) tick();
        n_chk++; if ({wr_acc, wr_ram} !== 2'b00) $display("FAIL beq_strb got %b exp %b", {wr_acc, wr_ram}, 2'b00); else n_pass++;
        tick();
        n_chk++; if (imem_addr !== 11'h010) $display("FAIL beq_pc got %h exp %h", imem_addr, 11'h010); else n_pass++;
        repeat (3) tick();
        n_chk++; if (imem_addr !== 11'h011) $display("FAIL bgt_nt got %h exp %h", imem_addr, 11'h011); else n_pass++;
    endtask

    task automatic test_flags_neg();
        clear_rom();
        rom[0] = 16'h3801; rom[1] = 16'h5900; rom[2] = 16'h6050;
        rom[11'h050] = 16'h1800; rom[11'h051] = 16'h6060; rom[11'h060] = 16'h4870;
        do_reset();
        tick(); tick();
        alu_res = 16'hFFFF;
        tick();
        alu_res = 16'h0000;
        repeat (3) tick();
        n_chk++; if (imem_addr !== 11'h002) $display("FAIL bge_nt got %h exp %h", imem_addr, 11'h002); else n_pass++;
        repeat (3) tick();
        n_chk++; if (imem_addr !== 11'h050) $display("FAIL blt_t got %h exp %h", imem_addr, 11'h050); else n_pass++;
        repeat (3) tick();
        n_chk++; if (imem_addr !== 11'h051) $display("FAIL ldi_pc got %h exp %h", imem_addr, 11'h051); else n_pass++;
        repeat (3) tick();
        n_chk++; if (imem_addr !== 11'h060) $display("FAIL ldi_hold got %h exp %h", imem_addr, 11'h060); else n_pass++;
        repeat (3) tick();
        n_chk++; if (imem_addr !== 11'h070) $display("FAIL bne_t got %h exp %h", imem_addr, 11'h070); else n_pass++;
    endtask

    task automatic test_pc_wrap();
        clear_rom();
        rom[0] = 16'h77FF;
        do_reset();
        repeat (3) tick();
        n_chk++; if (imem_addr !== 11'h7FF) $display("FAIL jmp_pc got %h exp %h", imem_addr, 11'h7FF); else n_pass++;
        tick(); tick();
        n_chk++; if ({wr_acc, wr_ram, acc_sel} !== 4'b0) $display("FAIL nop_ctl got %b exp %b", {wr_acc, wr_ram, acc_sel}, 4'b0); else n_pass++;
        tick();
        n_chk++; if (imem_addr !== 11'h000) $display("FAIL wrap_pc got %h exp %h", imem_addr, 11'h000); else n_pass++;
    endtask

    task automatic test_imm_sto();
        clear_rom();
        rom[0] = 16'h1FFF; rom[1] = 16'h0820; rom[2] = 16'h1030; rom[3] = 16'h2040;
        do_reset();
        tick(); tick();
        n_chk++; if ({wr_acc, acc_sel, imm} !== {1'b1, 2'b10, 16'hFFFF}) $display("FAIL ldi_sext got %h exp %h", {wr_acc, acc_sel, imm}, {1'b1, 2'b10, 16'hFFFF}); else n_pass++;
        tick(); tick();
        n_chk++; if (wr_ram !== 1'b0) $display("FAIL sto_load got %b exp %b", wr_ram, 1'b0); else n_pass++;
        tick();
        n_chk++; if ({wr_ram, wr_acc, ram_addr} !== {1'b1, 1'b0, 11'h020}) $display("FAIL sto_exec got %h exp %h", {wr_ram, wr_acc, ram_addr}, {1'b1, 1'b0, 11'h020}); else n_pass++;
        tick();
        n_chk++; if (wr_ram !== 1'b0) $display("FAIL sto_one got %b exp %b", wr_ram, 1'b0); else n_pass++;
        tick(); tick();
        n_chk++; if ({alu_b_sel, acc_sel, wr_acc, ram_addr} !== {1'b0, 2'b01, 1'b1, 11'h030}) $display("FAIL ld_ctl got %h exp %h", {alu_b_sel, acc_sel, wr_acc, ram_addr}, {1'b0, 2'b01, 1'b1, 11'h030}); else n_pass++;
        repeat (3) tick();
        n_chk++; if ({alu_op, alu_b_sel, acc_sel, wr_acc, wr_ram} !== 6'b000010) $display("FAIL add_ctl got %b exp %b", {alu_op, alu_b_sel, acc_sel, wr_acc, wr_ram}, 6'b000010); else n_pass++;
    endtask

    task automatic test_halt_reset();
        logic bad;
        clear_rom();
        rom[0] = 16'h1801; rom[1] = 16'h0000;
        do_reset();
        repeat (3) tick();
        tick(); tick();
        n_chk++; if (halted !== 1'b0) $display("FAIL hlt_exec got %b exp %b", halted, 1'b0); else n_pass++;
        tick();
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (halted !== 1'b1 || imem_addr !== 11'h001 || wr_acc !== 1'b0 || wr_ram !== 1'b0) bad = 1'b1;
            tick();
        end
        n_chk++; if (bad !== 1'b0) $display("FAIL halt_hold got %b exp %b", bad, 1'b0); else n_pass++;

        clear_rom();
        rom[0] = 16'h7123; rom[11'h123] = 16'h1807;
        do_reset();
        repeat (3) tick();
        n_chk++; if (imem_addr !== 11'h123) $display("FAIL jmp2_pc got %h exp %h", imem_addr, 11'h123); else n_pass++;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_chk++; if ({imem_addr, imm, wr_acc, wr_ram, halted} !== {11'h000, 16'h0000, 3'b000}) $display("FAIL midrst got %h exp %h", {imem_addr, imm, wr_acc, wr_ram, halted}, {11'h000, 16'h0000, 3'b000}); else n_pass++;
        tick(); tick();
        n_chk++; if ({wr_acc, ram_addr} !== {1'b0, 11'h123}) $display("FAIL midrst_jmp got %h exp %h", {wr_acc, ram_addr}, {1'b0, 11'h123}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_beq();
        test_flags_neg();
        test_pc_wrap();
        test_imm_sto();
        test_halt_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
